usb_msd_dma_mem_slv: RTL and testbench

// Wishbone B4 slave that serves the MSD DMA master port (the wb_msd_dma side of usb_wishbone).
// It terminates DMA read and write cycles into an internal word-addressed sector buffer.
// It supports classic cycles, incrementing bursts, programmable wait states and error termination.
// It also counts read and write beats so firmware and the bench can check DMA traffic.

---
 rtl/usb_msd_dma_mem_slv.sv | 159 +++++++++++++++
 tb/tb_usb_msd_dma_mem_slv.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_msd_dma_mem_slv.sv
// Wishbone B4 slave terminating MSD DMA traffic into a word-addressed sector buffer.
// Supports classic cycles, linear incrementing bursts, wait states, error termination and beat counters.
module usb_msd_dma_mem_slv #(
    parameter int AW          = 9,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [AW-1:0]    wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [2:0]       wb_cti_i,
    input  logic [1:0]       wb_bte_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic [CNT_W-1:0] rd_beats_o,
    output logic [CNT_W-1:0] wr_beats_o,
    input  logic             clr_cnt_i
);

    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BURST
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic             wrap_q, wrap_d;
    logic [2:0]       wcnt_q, wcnt_d;
    logic [31:0]      dat_q, dat_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]      mem [2**AW];

    logic req;
    logic beat_err;
    logic ack;
    logic err;
    logic mem_we;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    assign req    = wb_cyc_i & wb_stb_i;
    assign mem_we = ack & wb_we_i;

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        wrap_d   = wrap_q;
        wcnt_d   = wcnt_q;
        dat_d    = dat_q;
        beat_err = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d   = wb_adr_i;
                    wrap_d  = 1'b0;
                    wcnt_d  = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    wcnt_d  = 3'd0;
                end else if (wcnt_q == 3'd0) begin
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_ACK, S_BURST: begin
                // A stalled burst (stb low, cyc high) simply holds; a dropped ACK request aborts.
                if (!wb_cyc_i || (state_q == S_ACK && !wb_stb_i)) begin
                    state_d = S_IDLE;
                end else if (wb_stb_i) begin
                    beat_err = ((wb_cti_i == CTI_INCR) && (wb_bte_i != 2'b00))
                             || ((state_q == S_BURST) && (wrap_q || (wb_adr_i != adr_q)));
                    ack = !beat_err;
                    err = beat_err;
                    if (ack && (wb_cti_i == CTI_INCR)) begin
                        state_d = S_BURST;
                        adr_d   = adr_q + AW'(1);
                        wrap_d  = &adr_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Prefetch the word the next ack will return so burst beats run back to back.
        if (state_d == S_ACK || state_d == S_BURST) dat_d = mem[adr_d];
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (clr_cnt_i) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else if (ack) begin
            if (wb_we_i) wr_cnt_d = wr_cnt_q + CNT_W'(1);
            else         rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            wrap_q   <= 1'b0;
            wcnt_q   <= 3'd0;
            dat_q    <= 32'd0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            wrap_q   <= wrap_d;
            wcnt_q   <= wcnt_d;
            dat_q    <= dat_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (mem_we) mem[adr_q] <= merge_bytes(mem[adr_q], wb_dat_i, wb_sel_i);
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack;
    assign wb_err_o   = err;
    assign rd_beats_o = rd_cnt_q;
    assign wr_beats_o = wr_cnt_q;

endmodule

// File: tb/tb_usb_msd_dma_mem_slv.sv
// Bench for usb_msd_dma_mem_slv: instance 0 (AW=9, WAIT_CYCLES=2), instance 1 (AW=4, WAIT_CYCLES=3).
// Classic transfers come from a vector table; bursts, abort, clear and reset are hand sequences.
module tb_usb_msd_dma_mem_slv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic        clr [2];
    logic [31:0] wdat[2];
    logic [31:0] rdat[2];
    logic [3:0]  sel [2];
    logic [2:0]  cti [2];
    logic [1:0]  bte [2];
    logic        ack [2];
    logic        err [2];
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
    logic [8:0]  adr0;
    logic [3:0]  adr1;

    usb_msd_dma_mem_slv #(.AW(9), .WAIT_CYCLES(2), .CNT_W(16)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_we_i(we[0]), .wb_adr_i(adr0), .wb_dat_i(wdat[0]), .wb_sel_i(sel[0]),
        .wb_cti_i(cti[0]), .wb_bte_i(bte[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
        .wb_err_o(err[0]), .rd_beats_o(rdc[0]), .wr_beats_o(wrc[0]), .clr_cnt_i(clr[0])
    );

    usb_msd_dma_mem_slv #(.AW(4), .WAIT_CYCLES(3), .CNT_W(16)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_we_i(we[1]), .wb_adr_i(adr1), .wb_dat_i(wdat[1]), .wb_sel_i(sel[1]),
        .wb_cti_i(cti[1]), .wb_bte_i(bte[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
        .wb_err_o(err[1]), .rd_beats_o(rdc[1]), .wr_beats_o(wrc[1]), .clr_cnt_i(clr[1])
    );

    typedef struct {
        int          inst;
        logic        wr;
        logic [8:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sl;
        logic [2:0]  ct;
        logic [1:0]  bt;
        logic        exp_ack;
        logic [31:0] exp_dat;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        vt [21];
    logic [8:0]  bt_adr [4];
    logic [2:0]  bt_cti [4];
    logic [31:0] bt_dat [4];
    logic        res_ack[4];
    logic        res_err[4];
    logic [31:0] res_dat[4];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic set_beat(input int i, input logic [8:0] a, input logic [2:0] c, input logic [31:0] d);
        if (i == 0) adr0 = a;
        else        adr1 = a[3:0];
        cti[i]  = c;
        wdat[i] = d;
    endtask

    task automatic bus_idle(input int i);
        cyc[i] = 1'b0;
        stb[i] = 1'b0;
        we[i]  = 1'b0;
        sel[i] = 4'hF;
        bte[i] = 2'b00;
        set_beat(i, 9'h000, 3'b000, 32'h0);
    endtask

    // Runs n beats from bt_*; beats after the first must answer one per cycle.
    task automatic burst(input int i, input logic w, input logic [1:0] b, input int n,
                         input logic [3:0] s, output int lat);
        logic stop;
        for (int k = 0; k < 4; k++) begin
            res_ack[k] = 1'b0;
            res_err[k] = 1'b0;
            res_dat[k] = 32'h0;
        end
        lat    = -1;
        cyc[i] = 1'b1;
        stb[i] = 1'b1;
        we[i]  = w;
        bte[i] = b;
        sel[i] = s;
        set_beat(i, bt_adr[0], bt_cti[0], bt_dat[0]);
        for (int c = 0; c < 20; c++) begin
            if (lat < 0) begin
                @(negedge clk);
                if (ack[i] || err[i]) lat = c;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        stop = (lat < 0);
        for (int k = 0; k < n; k++) begin
            if (!stop) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                    set_beat(i, bt_adr[k], bt_cti[k], bt_dat[k]);
                    @(negedge clk);
                end
                res_ack[k] = ack[i];
                res_err[k] = err[i];
                res_dat[k] = rdat[i];
                if (!ack[i]) stop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus_idle(i);
    endtask

    task automatic xfer(input int i, input logic w, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                        output int lat);
        bt_adr[0] = a;
        bt_cti[0] = c;
        bt_dat[0] = d;
        burst(i, w, b, 1, s, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        got;
        logic [31:0] pre [4];
        pre = '{32'h1111_0100, 32'h2222_0101, 32'h3333_0102, 32'h4444_0103};

        vt[0]  = '{0, 1'b1, 9'h010, 32'hA5A5_1234, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd1,  16'd0};
        vt[1]  = '{0, 1'b0, 9'h010, 32'h0,         4'hF,    3'b000, 2'b00, 1'b1, 32'hA5A5_1234, 16'd1,  16'd1};
        vt[2]  = '{0, 1'b1, 9'h020, 32'hFFFF_FFFF, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd2,  16'd1};
        vt[3]  = '{0, 1'b1, 9'h020, 32'h1122_3344, 4'b0101, 3'b000, 2'b00, 1'b1, 32'h0,         16'd3,  16'd1};
        vt[4]  = '{0, 1'b0, 9'h020, 32'h0,         4'hF,    3'b000, 2'b00, 1'b1, 32'hFF22_FF44, 16'd3,  16'd2};
        vt[5]  = '{0, 1'b1, 9'h030, 32'h1234_5678, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd4,  16'd2};
        vt[6]  = '{0, 1'b1, 9'h030, 32'hDEAD_BEEF, 4'h0,    3'b000, 2'b00, 1'b1, 32'h0,         16'd5,  16'd2};
        vt[7]  = '{0, 1'b0, 9'h030, 32'h0,         4'hF,    3'b000, 2'b00, 1'b1, 32'h1234_5678, 16'd5,  16'd3};
        vt[8]  = '{0, 1'b0, 9'h010, 32'h0,         4'hF,    3'b000, 2'b01, 1'b1, 32'hA5A5_1234, 16'd5,  16'd4};
        vt[9]  = '{0, 1'b0, 9'h010, 32'h0,         4'hF,    3'b010, 2'b01, 1'b0, 32'h0,         16'd5,  16'd4};
        vt[10] = '{0, 1'b1, 9'h100, pre[0],        4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd6,  16'd4};
        vt[11] = '{0, 1'b1, 9'h101, pre[1],        4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd7,  16'd4};
        vt[12] = '{0, 1'b1, 9'h102, pre[2],        4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd8,  16'd4};
        vt[13] = '{0, 1'b1, 9'h103, pre[3],        4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd9,  16'd4};
        vt[14] = '{0, 1'b1, 9'h181, 32'h5555_AAAA, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd10, 16'd4};
        vt[15] = '{1, 1'b1, 9'h000, 32'h0000_AAAA, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd1,  16'd0};
        vt[16] = '{1, 1'b1, 9'h003, 32'h3333_3333, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd2,  16'd0};
        vt[17] = '{1, 1'b1, 9'h005, 32'hCAFE_F00D, 4'hF,    3'b000, 2'b00, 1'b1, 32'h0,         16'd3,  16'd0};
        vt[18] = '{1, 1'b0, 9'h005, 32'h0,         4'hF,    3'b000, 2'b00, 1'b1, 32'hCAFE_F00D, 16'd3,  16'd1};
        vt[19] = '{1, 1'b1, 9'h005, 32'h0,         4'hF,    3'b010, 2'b01, 1'b0, 32'h0,         16'd3,  16'd1};
        vt[20] = '{1, 1'b0, 9'h005, 32'h0,         4'hF,    3'b000, 2'b00, 1'b1, 32'hCAFE_F00D, 16'd3,  16'd2};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            clr[i] = 1'b0;
            bus_idle(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d ack", i), 32'(ack[i]), 32'd0);
            check($sformatf("rst%0d err", i), 32'(err[i]), 32'd0);
            check($sformatf("rst%0d dat", i), rdat[i], 32'd0);
            check($sformatf("rst%0d rdc", i), 32'(rdc[i]), 32'd0);
            check($sformatf("rst%0d wrc", i), 32'(wrc[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // Table of classic transfers
        for (int k = 0; k < 21; k++) begin
            xfer(vt[k].inst, vt[k].wr, vt[k].adr, vt[k].dat, vt[k].sl, vt[k].ct, vt[k].bt, lat);
            check($sformatf("v%0d latency", k), lat, (vt[k].inst == 1) ? 32'd4 : 32'd3);
            check($sformatf("v%0d ack", k), 32'(res_ack[0]), 32'(vt[k].exp_ack));
            check($sformatf("v%0d err", k), 32'(res_err[0]), 32'(!vt[k].exp_ack));
            if (!vt[k].wr && vt[k].exp_ack) check($sformatf("v%0d rdata", k), res_dat[0], vt[k].exp_dat);
            check($sformatf("v%0d wr_beats", k), 32'(wrc[vt[k].inst]), 32'(vt[k].exp_wr));
            check($sformatf("v%0d rd_beats", k), 32'(rdc[vt[k].inst]), 32'(vt[k].exp_rd));
        end

        // Four-beat incrementing read burst from 0x100
        for (int k = 0; k < 4; k++) begin
            bt_adr[k] = 9'h100 + 9'(k);
            bt_cti[k] = (k == 3) ? 3'b111 : 3'b010;
            bt_dat[k] = 32'h0;
        end
        burst(0, 1'b0, 2'b00, 4, 4'hF, lat);
        check("rburst latency", lat, 32'd3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rburst beat%0d ack", k), 32'(res_ack[k]), 32'd1);
            check($sformatf("rburst beat%0d data", k), res_dat[k], pre[k]);
        end
        check("rburst rd_beats", 32'(rdc[0]), 32'd8);

        // Second beat presents the wrong address
        bt_adr[0] = 9'h100; bt_cti[0] = 3'b010;
        bt_adr[1] = 9'h105; bt_cti[1] = 3'b010;
        burst(0, 1'b0, 2'b00, 2, 4'hF, lat);
        check("mismatch beat0 ack", 32'(res_ack[0]), 32'd1);
        check("mismatch beat0 data", res_dat[0], pre[0]);
        check("mismatch beat1 err", 32'(res_err[1]), 32'd1);
        check("mismatch beat1 ack", 32'(res_ack[1]), 32'd0);
        check("mismatch rd_beats", 32'(rdc[0]), 32'd9);
        xfer(0, 1'b0, 9'h101, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("after mismatch latency", lat, 32'd3);
        check("after mismatch data", res_dat[0], pre[1]);
        check("after mismatch rd_beats", 32'(rdc[0]), 32'd10);

        // Two-beat write burst, then read back
        bt_adr[0] = 9'h140; bt_cti[0] = 3'b010; bt_dat[0] = 32'hAAAA_0140;
        bt_adr[1] = 9'h141; bt_cti[1] = 3'b111; bt_dat[1] = 32'hBBBB_0141;
        burst(0, 1'b1, 2'b00, 2, 4'hF, lat);
        check("wburst beat0 ack", 32'(res_ack[0]), 32'd1);
        check("wburst beat1 ack", 32'(res_ack[1]), 32'd1);
        check("wburst wr_beats", 32'(wrc[0]), 32'd12);
        xfer(0, 1'b0, 9'h141, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("wburst readback 0x141", res_dat[0], 32'hBBBB_0141);
        xfer(0, 1'b0, 9'h140, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("wburst readback 0x140", res_dat[0], 32'hAAAA_0140);
        check("wburst rd_beats", 32'(rdc[0]), 32'd12);

        // AW=4 burst running off the top of the buffer
        bt_adr[0] = 9'h00F; bt_cti[0] = 3'b010; bt_dat[0] = 32'hFFFF_000F;
        bt_adr[1] = 9'h000; bt_cti[1] = 3'b111; bt_dat[1] = 32'hBADB_AD00;
        burst(1, 1'b1, 2'b00, 2, 4'hF, lat);
        check("wrap latency", lat, 32'd4);
        check("wrap beat0 ack", 32'(res_ack[0]), 32'd1);
        check("wrap beat1 err", 32'(res_err[1]), 32'd1);
        check("wrap beat1 ack", 32'(res_ack[1]), 32'd0);
        check("wrap wr_beats", 32'(wrc[1]), 32'd4);
        xfer(1, 1'b0, 9'h000, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("wrap mem[0] kept", res_dat[0], 32'h0000_AAAA);
        xfer(1, 1'b0, 9'h00F, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("wrap mem[F] written", res_dat[0], 32'hFFFF_000F);
        check("wrap rd_beats", 32'(rdc[1]), 32'd4);

        // Write abandoned in its wait phase: stb drops in cycle 2
        set_beat(1, 9'h003, 3'b000, 32'hBAD0_BAD0);
        we[1]  = 1'b1;
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("abort cycle%0d ack|err", c), {30'd0, ack[1], err[1]}, 32'd0);
            @(posedge clk);
            #1;
            if (c == 1) stb[1] = 1'b0;
        end
        bus_idle(1);
        check("abort wr_beats", 32'(wrc[1]), 32'd4);
        xfer(1, 1'b0, 9'h003, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("abort next latency", lat, 32'd4);
        check("abort mem unchanged", res_dat[0], 32'h3333_3333);
        check("abort rd_beats", 32'(rdc[1]), 32'd5);

        // Counter clear wins over a simultaneous ack
        clr[0] = 1'b1;
        xfer(0, 1'b1, 9'h150, 32'h1501_5015, 4'hF, 3'b000, 2'b00, lat);
        clr[0] = 1'b0;
        check("clr ack", 32'(res_ack[0]), 32'd1);
        check("clr wr_beats", 32'(wrc[0]), 32'd0);
        check("clr rd_beats", 32'(rdc[0]), 32'd0);
        xfer(0, 1'b0, 9'h150, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("post-clr data", res_dat[0], 32'h1501_5015);
        check("post-clr rd_beats", 32'(rdc[0]), 32'd1);
        check("post-clr wr_beats", 32'(wrc[0]), 32'd0);

        // Reset arriving during the second beat of a write burst
        set_beat(0, 9'h180, 3'b010, 32'h0000_0180);
        we[0]  = 1'b1;
        sel[0] = 4'hF;
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        got    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!got) begin
                @(negedge clk);
                if (ack[0]) got = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        check("rstmid beat0 ack", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        set_beat(0, 9'h181, 3'b111, 32'hDEAD_0181);
        #2;
        rst[0] = 1'b1;
        #1;
        check("rstmid ack", 32'(ack[0]), 32'd0);
        check("rstmid err", 32'(err[0]), 32'd0);
        check("rstmid dat", rdat[0], 32'd0);
        check("rstmid wr_beats", 32'(wrc[0]), 32'd0);
        check("rstmid rd_beats", 32'(rdc[0]), 32'd0);
        @(posedge clk);
        #1;
        bus_idle(0);
        rst[0] = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 9'h181, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("rstmid uncommitted beat", res_dat[0], 32'h5555_AAAA);
        xfer(0, 1'b0, 9'h180, 32'h0, 4'hF, 3'b000, 2'b00, lat);
        check("rstmid committed beat", res_dat[0], 32'h0000_0180);
        check("rstmid rd after", 32'(rdc[0]), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
